// File: rtl/mem_port_arbiter.sv
// Two-requester front end for the single-port cache_ctrl user interface.
// Each transfer runs IDLE -> ISSUE -> CHECK -> (WAIT) -> DONE; a write with an empty mask skips to DONE.
module mem_port_arbiter #(
   parameter int AW        = 32,
   parameter int PRIO_MODE = 0,
   parameter int TIMEOUT   = 4096
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i0_req,
   input  logic          i0_we,
   input  logic [AW-1:0] i0_addr,
   input  logic [31:0]   i0_wdata,
   input  logic [3:0]    i0_mask,
   output logic          o0_ack,
   output logic [31:0]   o0_rdata,
   input  logic          i1_req,
   input  logic          i1_we,
   input  logic [AW-1:0] i1_addr,
   input  logic [31:0]   i1_wdata,
   input  logic [3:0]    i1_mask,
   output logic          o1_ack,
   output logic [31:0]   o1_rdata,
   output logic          m_rd_en,
   output logic          m_wr_en,
   output logic [AW-1:0] m_addr,
   output logic [31:0]   m_wdata,
   output logic [3:0]    m_mask,
   input  logic [31:0]   m_rdata,
   input  logic          m_busy,
   output logic          o_grant,
   output logic          o_timeout
);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      CHECK = 3'd2,
      WAIT  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t          state_r;
   state_t          state_s;
   logic            grant_s;
   logic            start_s;
   logic            sel_we_s;
   logic [AW-1:0]   sel_addr_s;
   logic [31:0]     sel_wdata_s;
   logic [3:0]      sel_mask_s;
   logic            xfer_g_s;
   logic            xfer_we_s;
   logic [31:0]     done_data_s;
   logic            to_hit_s;
   logic            we_r;
   logic            last_r;
   logic [31:0]     rdata_r;
   logic [CW-1:0]   cnt_r;

   assign start_s     = (state_r == IDLE) && (i0_req || i1_req);
   assign sel_we_s    = grant_s ? i1_we    : i0_we;
   assign sel_addr_s  = grant_s ? i1_addr  : i0_addr;
   assign sel_wdata_s = grant_s ? i1_wdata : i0_wdata;
   assign sel_mask_s  = grant_s ? i1_mask  : i0_mask;
   // A mask-0 write reaches DONE straight from IDLE, so owner and direction come from the live selection.
   assign xfer_g_s    = start_s ? grant_s  : o_grant;
   assign xfer_we_s   = start_s ? sel_we_s : we_r;
   assign done_data_s = xfer_we_s ? 32'h0000_0000 : ((state_r == WAIT) ? m_rdata : rdata_r);
   assign to_hit_s    = (TIMEOUT != 0) && (state_r == WAIT) && (cnt_r == CW'(TIMEOUT));

   // Arbitration and next-state selection
   always_comb begin
      state_s = state_r;
      grant_s = 1'b0;
      if (i0_req && i1_req) begin
         if (PRIO_MODE == 1) begin
            grant_s = 1'b1;
         end else begin
            grant_s = ~last_r;
         end
      end else if (i1_req) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
      case (state_r)
         IDLE: begin
            if (start_s) begin
               if (sel_we_s && (sel_mask_s == 4'b0000)) begin
                  state_s = DONE;
               end else begin
                  state_s = ISSUE;
               end
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: state_s = CHECK;
         CHECK: begin
            if (m_busy) begin
               state_s = WAIT;
            end else begin
               state_s = DONE;
            end
         end
         WAIT: begin
            if (m_busy) begin
               state_s = WAIT;
            end else begin
               state_s = DONE;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State, latched transfer and all registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         we_r      <= 1'b0;
         last_r    <= 1'b1;
         rdata_r   <= 32'h0000_0000;
         cnt_r     <= {CW{1'b0}};
         o_grant   <= 1'b0;
         o_timeout <= 1'b0;
         m_rd_en   <= 1'b0;
         m_wr_en   <= 1'b0;
         m_addr    <= {AW{1'b0}};
         m_wdata   <= 32'h0000_0000;
         m_mask    <= 4'b0000;
         o0_ack    <= 1'b0;
         o1_ack    <= 1'b0;
         o0_rdata  <= 32'h0000_0000;
         o1_rdata  <= 32'h0000_0000;
      end else begin
         state_r <= state_s;
         m_rd_en <= (state_s == ISSUE) && !sel_we_s;
         m_wr_en <= (state_s == ISSUE) && sel_we_s;
         if (start_s) begin
            o_grant <= grant_s;
            we_r    <= sel_we_s;
            m_addr  <= sel_addr_s;
            m_wdata <= sel_wdata_s;
            m_mask  <= sel_we_s ? sel_mask_s : 4'b1111;
         end
         if ((state_r == ISSUE) || ((state_r == WAIT) && !m_busy)) begin
            rdata_r <= m_rdata;
         end
         if (state_r == CHECK) begin
            cnt_r <= {CW{1'b0}};
         end else if ((state_r == WAIT) && (cnt_r != {CW{1'b1}})) begin
            cnt_r <= cnt_r + CW'(1);
         end
         if (to_hit_s) begin
            o_timeout <= 1'b1;
         end
         if (state_r == DONE) begin
            last_r <= o_grant;
         end
         o0_ack   <= (state_s == DONE) && !xfer_g_s;
         o1_ack   <= (state_s == DONE) && xfer_g_s;
         o0_rdata <= ((state_s == DONE) && !xfer_g_s) ? done_data_s : 32'h0000_0000;
         o1_rdata <= ((state_s == DONE) && xfer_g_s) ? done_data_s : 32'h0000_0000;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, grant alternation, timeout/reset, then random traffic.
module tb_mem_port_arbiter;
   logic        clk;
   logic        rst;
   logic        i0_req, i0_we, i1_req, i1_we;
   logic [31:0] i0_addr, i0_wdata, i1_addr, i1_wdata;
   logic [3:0]  i0_mask, i1_mask;
   logic        o0_ack, o1_ack;
   logic [31:0] o0_rdata, o1_rdata;
   logic        m_rd_en, m_wr_en, m_busy, o_grant, o_timeout;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_mask;
   int          errors = 0;
   int          checks = 0;

   typedef struct {
      logic        port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
      int          busy_len;
      logic [31:0] mdata;
      int          lat;
      logic [31:0] rdata;
      int          nrd;
      int          nwr;
   } vec_t;

   vec_t vecs[8];

   mem_port_arbiter #(.AW(32), .PRIO_MODE(0), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .i0_req(i0_req), .i0_we(i0_we), .i0_addr(i0_addr), .i0_wdata(i0_wdata), .i0_mask(i0_mask),
      .o0_ack(o0_ack), .o0_rdata(o0_rdata),
      .i1_req(i1_req), .i1_we(i1_we), .i1_addr(i1_addr), .i1_wdata(i1_wdata), .i1_mask(i1_mask),
      .o1_ack(o1_ack), .o1_rdata(o1_rdata),
      .m_rd_en(m_rd_en), .m_wr_en(m_wr_en), .m_addr(m_addr), .m_wdata(m_wdata), .m_mask(m_mask),
      .m_rdata(m_rdata), .m_busy(m_busy), .o_grant(o_grant), .o_timeout(o_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_req(input logic p, input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask);
      if (p == 1'b0) begin
         i0_req = req; i0_we = we; i0_addr = addr; i0_wdata = wdata; i0_mask = mask;
      end else begin
         i1_req = req; i1_we = we; i1_addr = addr; i1_wdata = wdata; i1_mask = mask;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_acks"}, {30'd0, o0_ack, o1_ack}, 32'd0);
      chk({tag, "_rdata"}, o0_rdata | o1_rdata, 32'd0);
      chk({tag, "_en"}, {30'd0, m_rd_en, m_wr_en}, 32'd0);
      chk({tag, "_maddr"}, m_addr | m_wdata, 32'd0);
      chk({tag, "_mmask"}, {28'd0, m_mask}, 32'd0);
      chk({tag, "_grant_to"}, {30'd0, o_grant, o_timeout}, 32'd0);
   endtask

   // One transfer on an idle arbiter; cycle k is the k-th cycle after the edge that samples req.
   task automatic run_vec(input vec_t v, input string tag);
      int          ack_cyc = -1;
      int          nrd = 0;
      int          nwr = 0;
      int          unstable = 0;
      int          other_bad = 0;
      logic [31:0] got = 32'd0;
      logic [3:0]  exp_mask;
      exp_mask = v.we ? v.mask : 4'b1111;
      m_busy = 1'b0;
      set_req(v.port, 1'b1, v.we, v.addr, v.wdata, v.mask);
      for (int k = 1; (k <= 40) && (ack_cyc < 0); k++) begin
         @(negedge clk);
         nrd += int'(m_rd_en);
         nwr += int'(m_wr_en);
         if (m_addr !== v.addr || m_mask !== exp_mask || (v.we && m_wdata !== v.wdata)) unstable++;
         if ((v.port ? o0_ack : o1_ack) || (v.port ? o0_rdata : o1_rdata) !== 32'd0) other_bad++;
         if (m_rd_en || m_wr_en) m_rdata = (v.busy_len == 0) ? v.mdata : ~v.mdata;
         if (v.busy_len > 0 && k >= 2 && k <= v.busy_len + 1) begin
            m_busy = 1'b1;
         end else if (v.busy_len > 0 && k == v.busy_len + 2) begin
            m_busy = 1'b0;
            m_rdata = v.mdata;
         end
         if (v.port ? o1_ack : o0_ack) begin
            ack_cyc = k;
            got = v.port ? o1_rdata : o0_rdata;
            chk({tag, "_grant"}, {31'd0, o_grant}, {31'd0, v.port});
            set_req(v.port, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
         end
      end
      chk({tag, "_latency"}, ack_cyc, v.lat);
      chk({tag, "_rdata"}, got, v.rdata);
      chk({tag, "_rd_pulses"}, nrd, v.nrd);
      chk({tag, "_wr_pulses"}, nwr, v.nwr);
      chk({tag, "_stable"}, unstable, 0);
      chk({tag, "_other_quiet"}, other_bad, 0);
      m_busy = 1'b0;
      set_req(v.port, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      @(negedge clk);
   endtask

   // Both ports keep reading; grants must alternate and each ack must carry its own address tag.
   task automatic run_alternate();
      logic [31:0] a0 = 32'h1000_0000;
      logic [31:0] a1 = 32'h2000_0000;
      int          nack = 0;
      set_req(1'b0, 1'b1, 1'b0, a0, 32'd0, 4'd0);
      set_req(1'b1, 1'b1, 1'b0, a1, 32'd0, 4'd0);
      for (int k = 0; (k < 60) && (nack < 4); k++) begin
         @(negedge clk);
         if (m_rd_en) m_rdata = m_addr ^ 32'h5A5A_5A5A;
         if (o0_ack || o1_ack) begin
            chk("alt_port", {31'd0, o1_ack}, nack % 2);
            chk("alt_single", {31'd0, o0_ack & o1_ack}, 32'd0);
            if (o0_ack) begin
               chk("alt_data0", o0_rdata, a0 ^ 32'h5A5A_5A5A);
               a0 = a0 + 32'd4;
               i0_addr = a0;
            end else begin
               chk("alt_data1", o1_rdata, a1 ^ 32'h5A5A_5A5A);
               a1 = a1 + 32'd4;
               i1_addr = a1;
            end
            nack++;
         end
      end
      chk("alt_count", nack, 4);
      set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      @(negedge clk);
      @(negedge clk);
   endtask

   // Busy stuck high: timeout must rise and stick; a reset in WAIT clears everything and work resumes.
   task automatic run_timeout_reset();
      int   acks = 0;
      int   nrd = 0;
      vec_t nv;
      m_busy = 1'b0;
      set_req(1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'd0, 4'd0);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         nrd += int'(m_rd_en);
         acks += int'(o0_ack) + int'(o1_ack);
         if (k >= 2) m_busy = 1'b1;
         if (k == 9) chk("to_not_yet", {31'd0, o_timeout}, 32'd0);
         if (k == 14) chk("to_set", {31'd0, o_timeout}, 32'd1);
         if (k == 20) chk("to_sticky", {31'd0, o_timeout}, 32'd1);
      end
      chk("to_no_ack", acks, 0);
      chk("to_one_rd", nrd, 1);
      rst = 1'b1;
      #1;
      chk_zero("rst_wait");
      set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      m_busy = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      nv = '{1'b1, 1'b0, 32'h0000_0500, 32'd0, 4'd0, 0, 32'h600D_CAFE, 3, 32'h600D_CAFE, 1, 0};
      run_vec(nv, "after_rst");
   endtask

   // Random traffic from both requesters against a transaction-level model of the arbiter.
   task automatic run_random(input int ncyc);
      logic        pend[2], pwe[2];
      logic [31:0] paddr[2], pwdata[2];
      logic [3:0]  pmask[2];
      logic        free = 1'b1, last = 1'b1, active = 1'b0, busy_phase = 1'b0, ack_now;
      logic        cur_g = 1'b0, cur_we = 1'b0;
      logic [31:0] cur_addr = 32'd0, cur_wdata = 32'd0, cur_rdata = 32'd0;
      logic [3:0]  cur_mask = 4'd0;
      int          exp_issue = -1, exp_ack = -1, rem = 0;
      for (int p = 0; p < 2; p++) pend[p] = 1'b0;
      for (int cyc = 0; cyc < ncyc; cyc++) begin
         @(negedge clk);
         ack_now = 1'b0;
         if (cyc == exp_issue) begin
            chk("rnd_issue_rd", {31'd0, m_rd_en}, {31'd0, !cur_we});
            chk("rnd_issue_wr", {31'd0, m_wr_en}, {31'd0, cur_we});
            chk("rnd_issue_idle_bus", {31'd0, m_busy}, 32'd0);
            chk("rnd_grant", {31'd0, o_grant}, {31'd0, cur_g});
            chk("rnd_addr", m_addr, cur_addr);
            chk("rnd_mask", {28'd0, m_mask}, {28'd0, cur_we ? cur_mask : 4'b1111});
            if (cur_we) chk("rnd_wdata", m_wdata, cur_wdata);
            active = 1'b1;
            if ($urandom_range(0, 1) == 0) begin
               m_rdata = cur_rdata;
               exp_ack = cyc + 2;
            end else begin
               m_rdata = ~cur_rdata;
               rem = $urandom_range(1, 5);
               busy_phase = 1'b1;
            end
         end else begin
            chk("rnd_no_en", {30'd0, m_rd_en, m_wr_en}, 32'd0);
            if (active) begin
               chk("rnd_hold_addr", m_addr, cur_addr);
               chk("rnd_hold_mask", {28'd0, m_mask}, {28'd0, cur_we ? cur_mask : 4'b1111});
            end
            if (busy_phase) begin
               if (rem > 0) begin
                  m_busy = 1'b1;
                  rem--;
               end else begin
                  m_busy = 1'b0;
                  m_rdata = cur_rdata;
                  busy_phase = 1'b0;
                  exp_ack = cyc + 1;
               end
            end
         end
         chk("rnd_ack0", {31'd0, o0_ack}, {31'd0, (cyc == exp_ack) && !cur_g});
         chk("rnd_ack1", {31'd0, o1_ack}, {31'd0, (cyc == exp_ack) && cur_g});
         chk("rnd_rdata0", o0_rdata, ((cyc == exp_ack) && !cur_g) ? cur_rdata : 32'd0);
         chk("rnd_rdata1", o1_rdata, ((cyc == exp_ack) && cur_g) ? cur_rdata : 32'd0);
         if (cyc == exp_ack) begin
            chk("rnd_ack_grant", {31'd0, o_grant}, {31'd0, cur_g});
            chk("rnd_no_timeout", {31'd0, o_timeout}, 32'd0);
            last = cur_g;
            pend[cur_g] = 1'b0;
            set_req(cur_g, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
            exp_ack = -1;
            exp_issue = -1;
            active = 1'b0;
            ack_now = 1'b1;
         end
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && !(ack_now && (cur_g == p[0])) && ($urandom_range(0, 2) == 0)) begin
               pend[p] = 1'b1;
               pwe[p] = 1'($urandom_range(0, 1));
               paddr[p] = $urandom() & 32'hFFFF_FFFC;
               pwdata[p] = $urandom();
               pmask[p] = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
               set_req(p[0], 1'b1, pwe[p], paddr[p], pwdata[p], pmask[p]);
            end
         end
         if (free && (pend[0] || pend[1])) begin
            cur_g = (pend[0] && pend[1]) ? !last : pend[1];
            cur_we = pwe[cur_g];
            cur_addr = paddr[cur_g];
            cur_wdata = pwdata[cur_g];
            cur_mask = pmask[cur_g];
            cur_rdata = cur_we ? 32'd0 : $urandom();
            if (cur_we && cur_mask == 4'b0000) exp_ack = cyc + 1;
            else exp_issue = cyc + 1;
            free = 1'b0;
         end
         if (ack_now) free = 1'b1;
      end
      set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      m_busy = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0000_0000, 4'b0000, 0, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 1, 0};
      vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 4'b0011, 5, 32'h0000_0000, 8, 32'h0000_0000, 0, 1};
      vecs[2] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0000_0000, 4'b0000, 3, 32'h1234_5678, 6, 32'h1234_5678, 1, 0};
      vecs[3] = '{1'b0, 1'b1, 32'h0000_0080, 32'h1111_2222, 4'b0000, 0, 32'h0000_0000, 1, 32'h0000_0000, 0, 0};
      vecs[4] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0000_0000, 4'b0000, 0, 32'hA5A5_5A5A, 3, 32'hA5A5_5A5A, 1, 0};
      vecs[5] = '{1'b1, 1'b1, 32'h0000_0090, 32'h3333_4444, 4'b0000, 0, 32'h0000_0000, 1, 32'h0000_0000, 0, 0};
      vecs[6] = '{1'b0, 1'b1, 32'h0000_0048, 32'h5555_6666, 4'b1111, 0, 32'h0000_0000, 3, 32'h0000_0000, 0, 1};
      vecs[7] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0000_0000, 4'b0000, 1, 32'h0BAD_F00D, 4, 32'h0BAD_F00D, 1, 0};
      rst = 1'b1;
      m_busy = 1'b0;
      m_rdata = 32'd0;
      set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
      run_alternate();
      run_timeout_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_random(3000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
